// File: rtl/alu16.sv
// alu16: 16-bit signed combinational ALU with add/sub, multiply (native and
// Booth-recoded), divide (native and non-restoring), shifts and logic ops.
// The outputs are combinational. An asynchronous active-low reset forces
// them to their idle values. clk is carried only to keep the common port
// shape; no state is held anywhere.
module alu16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  op,
  output logic [15:0] out,
  output logic        overflow,
  output logic        zero
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_OR    = 4'b1010;
  localparam logic [3:0] OP_BOOTH = 4'b1011;
  localparam logic [3:0] OP_NRDIV = 4'b1100;

  // clk has no function here; tie it off so it is visibly intentional.
  logic unused_clk;
  assign unused_clk = clk;

  logic [15:0] sum;
  logic [15:0] diff;
  logic [31:0] mul_prod;
  logic [31:0] booth_prod;
  logic [15:0] div_quot;
  logic [15:0] nr_quot;
  logic        div_by_zero;
  logic        div_ovf;
  logic [15:0] res;
  logic        res_ovf;

  assign sum      = A + B;
  assign diff     = A - B;
  assign mul_prod = 32'($signed(A) * $signed(B));

  assign div_by_zero = (B == 16'h0000);
  assign div_ovf     = (A == 16'h8000) && (B == 16'hFFFF);

  // Native signed divide; the divisor is steered away from zero so the
  // operator never sees it (that case is overridden in the result mux).
  always_comb begin
    logic [15:0] safe_b;
    safe_b   = div_by_zero ? 16'h0001 : B;
    div_quot = 16'($signed(A) / $signed(safe_b));
  end

  // Radix-2 Booth multiply, 16 unrolled steps. The accumulator is one bit
  // wider than the operands so that -32768 * -32768 does not wrap.
  always_comb begin
    logic [16:0] acc;
    logic [16:0] mcand;
    logic [15:0] q;
    logic        q_1;
    acc   = 17'd0;
    mcand = {A[15], A};
    q     = B;
    q_1   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case ({q[0], q_1})
        2'b01:   acc = acc + mcand;
        2'b10:   acc = acc - mcand;
        default: acc = acc;
      endcase
      q_1 = q[0];
      q   = {acc[0], q[15:1]};
      acc = {acc[16], acc[16:1]};
    end
    booth_prod = {acc[15:0], q};
  end

  // Non-restoring divide on operand magnitudes, then sign fix-up of the
  // quotient. -32768 has magnitude 16'h8000, which is exact as unsigned.
  always_comb begin
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [17:0] r;
    logic [15:0] q;
    dvd = A[15] ? (16'h0000 - A) : A;
    dvs = B[15] ? (16'h0000 - B) : B;
    r   = 18'd0;
    q   = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      if (!r[17]) begin
        r = {r[16:0], dvd[i]} - {2'b00, dvs};
      end else begin
        r = {r[16:0], dvd[i]} + {2'b00, dvs};
      end
      q[i] = ~r[17];
    end
    if (A[15] ^ B[15]) begin
      nr_quot = 16'h0000 - q;
    end else begin
      nr_quot = q;
    end
  end

  // Operation select: result and overflow flag before reset gating.
  always_comb begin
    res     = 16'h0000;
    res_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        res     = sum;
        res_ovf = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (A[15] != B[15]) && (diff[15] != A[15]);
      end
      OP_MUL: begin
        res     = mul_prod[15:0];
        res_ovf = !((&mul_prod[31:15]) || !(|mul_prod[31:15]));
      end
      OP_BOOTH: begin
        res     = booth_prod[15:0];
        res_ovf = !((&booth_prod[31:15]) || !(|booth_prod[31:15]));
      end
      OP_DIV, OP_NRDIV: begin
        if (div_by_zero) begin
          res     = 16'h0000;
          res_ovf = 1'b1;
        end else if (div_ovf) begin
          res     = 16'h8000;
          res_ovf = 1'b1;
        end else begin
          res     = (op == OP_DIV) ? div_quot : nr_quot;
          res_ovf = 1'b0;
        end
      end
      OP_SHL: begin
        res = (B >= 16'd16) ? 16'h0000 : (A << B[3:0]);
      end
      OP_SHR: begin
        res = (B >= 16'd16) ? 16'h0000 : (A >> B[3:0]);
      end
      OP_XOR:  res = A ^ B;
      OP_XNOR: res = ~(A ^ B);
      OP_NOT:  res = ~A;
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      default: begin
        res     = 16'h0000;
        res_ovf = 1'b1;
      end
    endcase
  end

  // Reset gating; zero is always taken from the final out value.
  always_comb begin
    if (!reset) begin
      out      = 16'h0000;
      overflow = 1'b0;
    end else begin
      out      = res;
      overflow = res_ovf;
    end
    zero = (out == 16'h0000);
  end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vectors with hand-computed results for alu16.
module tb_alu16;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
  logic [15:0] out;
  logic        overflow;
  logic        zero;

  int n_cmp;
  int n_bad;

  alu16 dut (
    .clk      (clk),
    .reset    (reset),
    .A        (a),
    .B        (b),
    .op       (op),
    .out      (out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic [3:0] vop, input logic [15:0] e_out, input logic e_ovf);
    a  = va;
    b  = vb;
    op = vop;
    #1;
    check_val({tag, ".out"}, out, e_out);
    check_val({tag, ".ovf"}, {15'd0, overflow}, {15'd0, e_ovf});
    check_val({tag, ".zero"}, {15'd0, zero}, {15'd0, (e_out == 16'h0000)});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    a     = 16'd5;
    b     = 16'd5;
    op    = 4'b0000;
    #3;
    // reset holds outputs idle regardless of inputs
    check_val("rst.out", out, 16'h0000);
    check_val("rst.ovf", {15'd0, overflow}, 16'h0000);
    check_val("rst.zero", {15'd0, zero}, 16'h0001);
    op = 4'b1111;
    #1;
    check_val("rst_illegal.ovf", {15'd0, overflow}, 16'h0000);
    op = 4'b0000;
    #1;
    // release away from any clk edge: result appears immediately
    reset = 1'b1;
    #1;
    check_val("release.out", out, 16'd10);

    @(negedge clk);
    vec("add_neg",   16'hFDEF, 16'd10,   4'b0000, 16'hFDF9, 1'b0);
    vec("sub",       16'd1245, 16'd433,  4'b0001, 16'd812,  1'b0);
    vec("add_ovf",   16'h7FFF, 16'd1,    4'b0000, 16'h8000, 1'b1);
    vec("sub_ovf",   16'h8000, 16'd1,    4'b0001, 16'h7FFF, 1'b1);
    vec("add_noovf", 16'hFFFF, 16'hFFFF, 4'b0000, 16'hFFFE, 1'b0);
    vec("mul_neg",   16'd30,   16'hFFD7, 4'b0010, 16'hFB32, 1'b0);
    vec("booth_pos", 16'd30,   16'd40,   4'b1011, 16'd1200, 1'b0);
    vec("booth_neg", 16'd30,   16'hFFD7, 4'b1011, 16'hFB32, 1'b0);
    vec("mul_ovf",   16'd300,  16'd300,  4'b0010, 16'h5F90, 1'b1);
    vec("booth_ovf", 16'd300,  16'd300,  4'b1011, 16'h5F90, 1'b1);
    vec("booth_min", 16'h8000, 16'h8000, 4'b1011, 16'h0000, 1'b1);
    vec("booth_edge",16'h8000, 16'hFFFF, 4'b1011, 16'h8000, 1'b1);
    vec("div",       16'd16900,16'd20,   4'b0011, 16'd845,  1'b0);
    vec("nrdiv",     16'd80,   16'd40,   4'b1100, 16'd2,    1'b0);
    vec("nrdiv_neg", 16'hFFF9, 16'd2,    4'b1100, 16'hFFFD, 1'b0);
    vec("div_neg",   16'hFFF9, 16'd2,    4'b0011, 16'hFFFD, 1'b0);
    vec("nrdiv_nn",  16'hFF9C, 16'hFFF9, 4'b1100, 16'd14,   1'b0);
    vec("div_b0",    16'd123,  16'd0,    4'b0011, 16'h0000, 1'b1);
    vec("nrdiv_b0",  16'd123,  16'd0,    4'b1100, 16'h0000, 1'b1);
    vec("div_min",   16'h8000, 16'hFFFF, 4'b0011, 16'h8000, 1'b1);
    vec("nrdiv_min", 16'h8000, 16'hFFFF, 4'b1100, 16'h8000, 1'b1);
    vec("nrdiv_m1",  16'h8000, 16'd1,    4'b1100, 16'h8000, 1'b0);
    vec("shl",       16'd85,   16'd4,    4'b0100, 16'd1360, 1'b0);
    vec("shr",       16'd167,  16'd3,    4'b0101, 16'd20,   1'b0);
    vec("shr_fill",  16'h8000, 16'd15,   4'b0101, 16'h0001, 1'b0);
    vec("shl_16",    16'hFFFF, 16'd16,   4'b0100, 16'h0000, 1'b0);
    vec("shr_16",    16'hFFFF, 16'd16,   4'b0101, 16'h0000, 1'b0);
    vec("shl_big",   16'd1,    16'h0100, 4'b0100, 16'h0000, 1'b0);
    vec("xor",       16'd8,    16'd12,   4'b0110, 16'd4,    1'b0);
    vec("xnor",      16'd6553, 16'd133,  4'b0111, 16'hE6E3, 1'b0);
    vec("not",       16'd123,  16'hAAAA, 4'b1000, 16'hFF84, 1'b0);
    vec("and",       16'd3,    16'd2,    4'b1001, 16'd2,    1'b0);
    vec("or",        16'd3,    16'd2,    4'b1010, 16'd3,    1'b0);
    vec("ill_d",     16'd7,    16'd7,    4'b1101, 16'h0000, 1'b1);
    vec("ill_f",     16'd5,    16'd5,    4'b1111, 16'h0000, 1'b1);

    // reset mid-sequence overrides at once, with no clk edge in between
    a     = 16'd7;
    b     = 16'd9;
    op    = 4'b0000;
    #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst.out", out, 16'h0000);
    check_val("mid_rst.zero", {15'd0, zero}, 16'h0001);
    reset = 1'b1;
    #1;
    check_val("mid_rel.out", out, 16'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu16.md
ALU16 -- requirements
Module: alu16

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; no datapath state, kept for the codebase's port convention.
REQ-003 reset  input  1  asynchronous active-low reset; low forces all outputs to their reset values.
REQ-004 A  input  16  signed two's-complement operand A.
REQ-005 B  input  16  signed operand B; unsigned shift amount for shift ops.
REQ-006 op  input  4  operation select.
REQ-007 out  output  16  signed result.
REQ-008 overflow  output  1  result not representable, or illegal operation.
REQ-009 zero  output  1  high when out == 16'h0000.

Function
REQ-010 When reset is high, the datapath SHALL be purely combinational: out, overflow and zero follow A, B and op with zero clock latency, independent of clk edges.
REQ-011 op 0000 ADD: out = A+B mod 2^16; overflow = signed overflow (operands same sign, result sign differs).
REQ-012 op 0001 SUB: out = A-B mod 2^16; overflow = signed overflow (operands differ in sign, result sign differs from A).
REQ-013 op 0010 MUL: out = low 16 bits of the 32-bit signed product A*B; overflow = 1 when the product is outside -32768..32767.
REQ-014 op 0011 DIV: out = signed quotient A/B, truncated toward zero.
REQ-015 op 0011 DIV, B=0: out = 0, overflow = 1.
REQ-016 op 0011 DIV, A=-32768 and B=-1: out = 16'h8000, overflow = 1.
REQ-017 op 0011 DIV, all other cases: overflow = 0.
REQ-018 op 0100 SHL: out = A logically shifted left by unsigned B; B >= 16 gives 0; overflow = 0.
REQ-019 op 0101 SHR: out = A logically shifted right by unsigned B, zero fill; B >= 16 gives 0; overflow = 0.
REQ-020 op 0110 XOR: out = A^B.
REQ-021 op 0111 XNOR: out = ~(A^B).
REQ-022 op 1000 NOT: out = ~A; B is ignored.
REQ-023 op 1001 AND: out = A&B.
REQ-024 op 1010 OR: out = A|B.
REQ-025 For ops 0110-1010, overflow SHALL be 0.
REQ-026 op 1011 BOOTH: signed multiply by radix-2 Booth recoding over 16 unrolled iterations (accumulator, Q, Q-1, arithmetic right shift); out and overflow are identical to op 0010 for all inputs.
REQ-027 op 1100 NRDIV: non-restoring division over 16 unrolled iterations on operand magnitudes, with sign fix-up; out and overflow are identical to op 0011 for all inputs, including B=0 and -32768/-1.
REQ-028 op 1101-1111: out = 0, overflow = 1 (illegal op).
REQ-029 zero SHALL be derived from the final out value in every mode, including reset and illegal ops.
REQ-030 Outputs SHALL be glitch-tolerant only; there is no handshake, and consumers sample them after the inputs have settled.

Reset
REQ-031 While reset is low: out = 0, overflow = 0, zero = 1, asynchronously, regardless of clk, A, B and op.
REQ-032 On reset release, outputs SHALL reflect the current inputs combinationally, with no wait for a clk edge.
REQ-033 Asserting reset mid-sequence SHALL override the result immediately; no state is retained.

Verification
REQ-034 ADD/SUB: A=-529, B=10, op=0000 -> out=16'hFDF9 (-519), zero=0.
REQ-035 ADD/SUB: A=1245, B=433, op=0001 -> out=812.
REQ-036 ADD/SUB: A=32767, B=1, op=0000 -> out=16'h8000, overflow=1.
REQ-037 MUL/BOOTH: A=30, B=-41, op=0010 -> out=16'hFB32 (-1230).
REQ-038 MUL/BOOTH: A=30, B=40, op=1011 -> out=1200.
REQ-039 MUL/BOOTH: A=300, B=300, op 0010 and op 1011 -> both give overflow=1 and identical out.
REQ-040 DIV/NRDIV: A=16900, B=20, op=0011 -> out=845.
REQ-041 DIV/NRDIV: A=80, B=40, op=1100 -> out=2.
REQ-042 DIV/NRDIV: A=-7, B=2, op=1100 -> out=-3.
REQ-043 DIV/NRDIV: B=0 -> out=0, overflow=1, zero=1.
REQ-044 Shifts: A=85, B=4, op=0100 -> out=1360.
REQ-045 Shifts: A=167, B=3, op=0101 -> out=20.
REQ-046 Shifts: B=16 -> out=0, zero=1.
REQ-047 Logic: XOR 8,12 -> 4; XNOR 6553,133 -> 16'hE6E3; NOT 123 -> 16'hFF84; AND 3,2 -> 2; OR 3,2 -> 3; all with overflow=0.
REQ-048 Reset/illegal: reset low with A=5, B=5, op=0000 -> out=0, zero=1.
REQ-049 Reset/illegal: after release, out=10.
REQ-050 Reset/illegal: op=1111 -> out=0, overflow=1.
